// File: rtl/evm_pkg.sv
// Shared types and constants for the EVM ballot controller.
// Holds the ballot FSM state type and the candidate encodings used on vote_sel.
package evm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAST    = 3'd2,
    RELEASE = 3'd3,
    CLOSED  = 3'd4
  } evm_ballot_state_t;

  localparam logic VOTE_SEL_C1 = 1'b0;
  localparam logic VOTE_SEL_C2 = 1'b1;

  function automatic logic is_busy(evm_ballot_state_t s);
    return (s != IDLE) && (s != CLOSED);
  endfunction

endpackage

// File: rtl/evm_sat_counter.sv
// Saturating up-counter: holds at all-ones rather than wrapping.
module evm_sat_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [N-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     count <= '0;
    else if (inc && count != '1) count <= count + N'(1);
  end

endmodule

// File: rtl/evm_ballot_ctrl.sv
// Presiding-officer ballot handshake: issue -> one voter press -> single-cycle vote.
// Define EVM_BALLOT_TIMEOUT_EN to withdraw ballots left unused for TIMEOUT cycles.
module evm_ballot_ctrl
  import evm_pkg::*;
#(
  parameter int N       = 4,
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         voting_status,
  input  logic         issue,
  input  logic         vote1,
  input  logic         vote2,
  output logic         enable,
  output logic         vote_valid,
  output logic         vote_sel,
  output logic         busy,
  output logic         poll_closed,
  output logic [N-1:0] ballots_issued,
  output logic [N-1:0] spoiled,
  output logic [N-1:0] timeouts
);

  evm_ballot_state_t state, nxt;
  logic issue_q, vote1_q, vote2_q;
  logic issue_e, vote1_e, vote2_e;
  logic inc_issue, inc_spoil, sel_nxt;

  // A level already high in the previous sample is never an edge, so a
  // button held across ballot issue must be released and pressed again.
  assign issue_e = issue & ~issue_q;
  assign vote1_e = vote1 & ~vote1_q;
  assign vote2_e = vote2 & ~vote2_q;

`ifdef EVM_BALLOT_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] timer;
  logic          to_hit, inc_to;

  assign to_hit = (timer == TW'(TIMEOUT - 1));

  // Timer only runs while a ballot is open, so it is zero on every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 timer <= '0;
    else if (state != ARMED) timer <= '0;
    else                     timer <= timer + TW'(1);
  end
`endif

  always_comb begin
    nxt       = state;
    inc_issue = 1'b0;
    inc_spoil = 1'b0;
    sel_nxt   = vote_sel;
`ifdef EVM_BALLOT_TIMEOUT_EN
    inc_to    = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!voting_status) nxt = CLOSED;
        else if (issue_e) begin
          nxt       = ARMED;
          inc_issue = 1'b1;
        end
      end
      ARMED: begin
        if (vote1_e && vote2_e) begin
          nxt       = RELEASE;
          inc_spoil = 1'b1;
        end else if (vote1_e || vote2_e) begin
          nxt     = CAST;
          sel_nxt = vote2_e ? VOTE_SEL_C2 : VOTE_SEL_C1;
        end
`ifdef EVM_BALLOT_TIMEOUT_EN
        else if (to_hit) begin
          nxt    = IDLE;
          inc_to = 1'b1;
        end
`endif
      end
      CAST:    nxt = RELEASE;
      RELEASE: if (!vote1 && !vote2) nxt = IDLE;
      CLOSED:  nxt = CLOSED;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are true registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      issue_q     <= 1'b0;
      vote1_q     <= 1'b0;
      vote2_q     <= 1'b0;
      enable      <= 1'b0;
      vote_valid  <= 1'b0;
      vote_sel    <= 1'b0;
      busy        <= 1'b0;
      poll_closed <= 1'b0;
    end else begin
      state       <= nxt;
      issue_q     <= issue;
      vote1_q     <= vote1;
      vote2_q     <= vote2;
      enable      <= (nxt == ARMED);
      vote_valid  <= (nxt == CAST);
      vote_sel    <= sel_nxt;
      busy        <= is_busy(nxt);
      poll_closed <= (nxt == CLOSED);
    end
  end

  evm_sat_counter #(.N(N)) u_cnt_issued (
    .clk(clk), .rst(rst), .inc(inc_issue), .count(ballots_issued)
  );

  evm_sat_counter #(.N(N)) u_cnt_spoiled (
    .clk(clk), .rst(rst), .inc(inc_spoil), .count(spoiled)
  );

`ifdef EVM_BALLOT_TIMEOUT_EN
  evm_sat_counter #(.N(N)) u_cnt_timeouts (
    .clk(clk), .rst(rst), .inc(inc_to), .count(timeouts)
  );
`else
  assign timeouts = '0;
`endif

endmodule

// File: tb/tb_evm_ballot_ctrl.sv
// Directed + random bench for evm_ballot_ctrl against a ballot-level reference model.
module tb_evm_ballot_ctrl;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int MAXC = (1 << N) - 1;

  logic clk = 1'b0, rst = 1'b0, vs = 1'b1, issue = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic enable, vote_valid, vote_sel, busy, poll_closed;
  logic [N-1:0] ballots_issued, spoiled, timeouts;

  evm_ballot_ctrl #(.N(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .voting_status(vs), .issue(issue), .vote1(v1), .vote2(v2),
    .enable(enable), .vote_valid(vote_valid), .vote_sel(vote_sel), .busy(busy),
    .poll_closed(poll_closed), .ballots_issued(ballots_issued), .spoiled(spoiled),
    .timeouts(timeouts)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int vv_seen = 0, en_seen = 0;

  // Reference model: ballot life expressed as flags and tallies.
  bit ballot_open, vote_pending, wait_release, poll_shut, chosen;
  int open_age, n_issued, n_spoiled, n_timeouts;
  bit last_issue, last_v1, last_v2;

  function automatic int bump(int x);
    return (x < MAXC) ? x + 1 : MAXC;
  endfunction

  function automatic void m_reset();
    ballot_open = 0; vote_pending = 0; wait_release = 0; poll_shut = 0; chosen = 0;
    open_age = 0; n_issued = 0; n_spoiled = 0; n_timeouts = 0;
    last_issue = 0; last_v1 = 0; last_v2 = 0;
  endfunction

  function automatic void m_step();
    bit pi, p1, p2;
    pi = issue && !last_issue;
    p1 = v1 && !last_v1;
    p2 = v2 && !last_v2;
    if (poll_shut) begin
    end else if (ballot_open) begin
      if (p1 && p2) begin
        n_spoiled = bump(n_spoiled); ballot_open = 0; wait_release = 1;
      end else if (p1 || p2) begin
        ballot_open = 0; vote_pending = 1; chosen = p2;
      end
`ifdef EVM_BALLOT_TIMEOUT_EN
      else if (open_age == TO - 1) begin
        n_timeouts = bump(n_timeouts); ballot_open = 0;
      end
`endif
      else open_age++;
    end else if (vote_pending) begin
      vote_pending = 0; wait_release = 1;
    end else if (wait_release) begin
      if (!v1 && !v2) wait_release = 0;
    end else begin
      if (!vs) poll_shut = 1;
      else if (pi) begin
        ballot_open = 1; open_age = 0; n_issued = bump(n_issued);
      end
    end
    last_issue = issue; last_v1 = v1; last_v2 = v2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("enable", {31'b0, enable}, {31'b0, ballot_open});
    chk("vote_valid", {31'b0, vote_valid}, {31'b0, vote_pending});
    if (vote_pending) chk("vote_sel", {31'b0, vote_sel}, {31'b0, chosen});
    chk("busy", {31'b0, busy}, {31'b0, ballot_open | vote_pending | wait_release});
    chk("poll_closed", {31'b0, poll_closed}, {31'b0, poll_shut});
    chk("ballots_issued", 32'(ballots_issued), n_issued);
    chk("spoiled", 32'(spoiled), n_spoiled);
    chk("timeouts", 32'(timeouts), n_timeouts);
  endtask

  task automatic cyc(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (!rst) m_step();
      @(negedge clk);
      if (vote_valid === 1'b1) vv_seen++;
      if (enable === 1'b1) en_seen++;
      check_all();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    vs = 1'b1; issue = 1'b0; v1 = 1'b0; v2 = 1'b0;
  endtask

  task automatic pulse_issue();
    issue = 1'b1; cyc(); issue = 1'b0;
  endtask

  int snap;

  initial begin
    m_reset();
    #2;
    do_reset();
    chk("reset_enable", {31'b0, enable}, 32'd0);

    // Normal vote: issue sampled at cycle 2, vote1 rises at cycle 6
    cyc(2);
    pulse_issue();
    cyc(3);
    vv_seen = 0;
    v1 = 1'b1; cyc(3);
    v1 = 1'b0; cyc(2);
    chk("normal_vv_count", vv_seen, 1);
    chk("normal_issued", 32'(ballots_issued), 1);
    chk("normal_idle", {31'b0, busy}, 32'd0);

    // Held button must be released and re-pressed
    vv_seen = 0;
    v2 = 1'b1; cyc(2);
    pulse_issue();
    cyc(3);
    chk("held_no_vote", vv_seen, 0);
    v2 = 1'b0; cyc();
    v2 = 1'b1; cyc(2);
    v2 = 1'b0; cyc(2);
    chk("held_vv_count", vv_seen, 1);

    // Spoiled ballot
    vv_seen = 0;
    pulse_issue();
    cyc(2);
    v1 = 1'b1; v2 = 1'b1; cyc();
    chk("spoil_enable_drop", {31'b0, enable}, 32'd0);
    cyc(3);
    v1 = 1'b0; cyc(2);
    chk("spoil_still_release", {31'b0, busy}, 32'd1);
    v2 = 1'b0; cyc(2);
    chk("spoil_no_vote", vv_seen, 0);
    chk("spoil_count", 32'(spoiled), 1);

    // Unused ballot
    en_seen = 0;
    pulse_issue();
    cyc(20);
`ifdef EVM_BALLOT_TIMEOUT_EN
    chk("to_enable_cycles", en_seen, 8);
    chk("to_count", 32'(timeouts), 1);
    chk("to_idle", {31'b0, busy}, 32'd0);
`else
    chk("no_to_still_open", {31'b0, enable}, 32'd1);
    chk("no_to_count", 32'(timeouts), 0);
    v1 = 1'b1; cyc(2); v1 = 1'b0; cyc(2);
`endif

    // Vote on the last open cycle beats the timeout
    snap = 32'(timeouts);
    vv_seen = 0;
    pulse_issue();
    cyc(7);
    v1 = 1'b1; cyc();
    v1 = 1'b0; cyc(3);
    chk("late_vote_vv", vv_seen, 1);
    chk("late_vote_to", 32'(timeouts), snap);

    // Close requested during an open ballot
    vv_seen = 0;
    pulse_issue();
    cyc();
    vs = 1'b0; cyc(2);
    v2 = 1'b1; cyc(2);
    v2 = 1'b0; cyc(3);
    chk("close_vote_accepted", vv_seen, 1);
    chk("close_poll_closed", {31'b0, poll_closed}, 32'd1);
    snap = 32'(ballots_issued);
    vs = 1'b1;
    pulse_issue();
    cyc(3);
    chk("close_issue_ignored", 32'(ballots_issued), snap);

    // Async reset while a ballot is open
    do_reset();
    pulse_issue();
    cyc(2);
    #2 rst = 1'b1;
    m_reset();
    #1;
    chk("async_rst_enable", {31'b0, enable}, 32'd0);
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Saturation of ballots_issued
    for (int i = 0; i < 17; i++) begin
      pulse_issue();
      cyc();
      v1 = 1'b1; cyc(2);
      v1 = 1'b0; cyc(2);
    end
    chk("sat_issued", 32'(ballots_issued), MAXC);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        vs    = ($urandom_range(0, 59) != 0);
        issue = ($urandom_range(0, 2) == 0);
        v1    = ($urandom_range(0, 3) == 0);
        v2    = ($urandom_range(0, 3) == 0);
        cyc();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
